// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with built-in prescaler, hex decode,
// inter-digit blanking and a double-buffered display image swapped only at frame boundaries.
module seg_scan_controller #(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] digit_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
    input  logic        load_i,
    output logic        update_pending_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_done_o
);

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(TICK_DIV - 2);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic          POL       = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick, boundary;

    logic [15:0]   disp_dig_q, pend_dig_q;
    logic [3:0]    disp_dp_q, pend_dp_q;
    logic [3:0]    disp_blank_q, pend_blank_q;
    logic          pending_q;
    logic          frame_done_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [3:0]    nib;
    logic [6:0]    seg_raw;
    logic [3:0]    an_raw;

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        boundary = tick && (state_q == S3);
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        state_d  = tick ? state_t'(state_q + 2'd1) : state_q;
        nib      = disp_dig_q[{state_q, 2'b00} +: 4];
        an_raw   = 4'b0000;
        if ((cnt_q >= BLANK_END) && !disp_blank_q[state_q]) begin
            an_raw[state_q] = 1'b1;
        end
    end

    // Active-high gfedcba codes; polarity is applied when registering.
    always_comb begin
        seg_raw = 7'h00;
        case (nib)
            4'h0: seg_raw = 7'h3F;
            4'h1: seg_raw = 7'h06;
            4'h2: seg_raw = 7'h5B;
            4'h3: seg_raw = 7'h4F;
            4'h4: seg_raw = 7'h66;
            4'h5: seg_raw = 7'h6D;
            4'h6: seg_raw = 7'h7D;
            4'h7: seg_raw = 7'h07;
            4'h8: seg_raw = 7'h7F;
            4'h9: seg_raw = 7'h6F;
            4'hA: seg_raw = 7'h77;
            4'hB: seg_raw = 7'h7C;
            4'hC: seg_raw = 7'h39;
            4'hD: seg_raw = 7'h5E;
            4'hE: seg_raw = 7'h79;
            4'hF: seg_raw = 7'h71;
            default: seg_raw = 7'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            state_q      <= S0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= {4{POL}};
            seg_q        <= {7{POL}};
            dp_q         <= POL;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            // Registered one cycle early so the pulse coincides with the boundary cycle.
            frame_done_q <= (cnt_q == CNT_PRE) && (state_q == S3);
            if (boundary && pending_q) begin
                disp_dig_q   <= pend_dig_q;
                disp_dp_q    <= pend_dp_q;
                disp_blank_q <= pend_blank_q;
            end
            if (load_i) begin
                pend_dig_q   <= digit_i;
                pend_dp_q    <= dp_i;
                pend_blank_q <= blank_i;
                pending_q    <= 1'b1;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end
            an_q  <= an_raw ^ {4{POL}};
            seg_q <= seg_raw ^ {7{POL}};
            dp_q  <= disp_dp_q[state_q] ^ POL;
        end
    end

    assign update_pending_o = pending_q;
    assign an_o             = an_q;
    assign seg_o            = seg_q;
    assign dp_o             = dp_q;
    assign frame_done_o     = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: expected digit slots are queued by the stimulus
// and popped by a monitor on every anode activation.
module tb_seg_scan_controller;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digit = 16'h0000;
    logic [3:0]  dpi = 4'h0;
    logic [3:0]  blk = 4'h0;
    logic        up, dp, fd;
    logic [3:0]  an;
    logic [6:0]  seg;

    int   checks = 0;
    int   passes = 0;
    int   rises = 0;
    logic up_prev = 1'b0;
    bit   prev_act = 1'b0;
    int   run = 0;
    exp_t q[$];

    seg_scan_controller #(
        .TICK_DIV    (8),
        .BLANK_CYCLES(2),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .digit_i         (digit),
        .dp_i            (dpi),
        .blank_i         (blk),
        .load_i          (load),
        .update_pending_o(up),
        .an_o            (an),
        .seg_o           (seg),
        .dp_o            (dp),
        .frame_done_o    (fd)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Queue one entry per digit that should light up; skip marks blanked or never-reached digits.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] skip);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (!skip[i]) begin
                e.an    = 4'hF;
                e.an[i] = 1'b0;
                e.seg   = ~hexseg(d[i*4 +: 4]);
                e.dp    = ~dpv[i];
                q.push_back(e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dv, input logic [3:0] bv);
        digit = d;
        dpi   = dv;
        blk   = bv;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
        digit = ~d;
        dpi   = ~dv;
        blk   = ~bv;
    endtask

    task automatic wait_fd(output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            cyc++;
            if (fd === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            $display("FAIL frame_done_timeout: no pulse within %0d cycles", cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b0) begin
            prev_act = 1'b0;
            run      = 0;
        end else if (an !== 4'hF) begin
            if (!prev_act) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_activation: an=%b seg=%h with no slot expected", an, seg);
                end else begin
                    e = q.pop_front();
                    chk("slot {an,seg,dp}", {20'h0, an, seg, dp}, {20'h0, e.an, e.seg, e.dp});
                end
            end
            prev_act = 1'b1;
            run++;
        end else begin
            if (prev_act) chk("slot_active_cycles", run, 6);
            prev_act = 1'b0;
            run      = 0;
        end
    end

    always @(negedge clk) begin
        if (up === 1'b1 && up_prev !== 1'b1) rises++;
        up_prev = up;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int r0;

        // Reset asserted mid-cycle after a short run
        #1 rst = 1'b1;
        #11 rst = 1'b0;
        step(2);
        #3 rst = 1'b1;
        #1;
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_frame_done", fd, 1'b0);
        chk("reset_update_pending", up, 1'b0);
        #2 rst = 1'b0;
        push_frame(16'h0000, 4'h0, 4'h0);
        wait_fd(cyc);
        chk("first_frame_cycles", cyc, 31);
        push_frame(16'h0000, 4'h0, 4'h0);

        // Scan order and frame period
        step(4);
        do_load(16'h4321, 4'h0, 4'h0);
        chk("pending_after_load", up, 1'b1);
        wait_fd(cyc);
        chk("pending_at_boundary", up, 1'b1);
        push_frame(16'h4321, 4'h0, 4'h0);
        step(1);
        chk("frame_done_width", fd, 1'b0);
        chk("pending_cleared", up, 1'b0);
        wait_fd(cyc);
        chk("frame_period", cyc + 1, 32);
        push_frame(16'h4321, 4'h0, 4'h0);

        // Load mid-frame does not tear the current frame
        step(10);
        do_load(16'hABCD, 4'h0, 4'h0);
        chk("tear_pending_set", up, 1'b1);
        wait_fd(cyc);
        chk("tear_pending_held", up, 1'b1);
        push_frame(16'hABCD, 4'h0, 4'h0);
        step(1);
        chk("tear_pending_cleared", up, 1'b0);

        // Last load wins, one pending episode
        r0 = rises;
        step(2);
        do_load(16'h1111, 4'h0, 4'h0);
        step(6);
        do_load(16'h2222, 4'h0, 4'h0);
        wait_fd(cyc);
        push_frame(16'h2222, 4'h0, 4'h0);
        step(1);
        chk("lastwin_pending_cleared", up, 1'b0);
        chk("lastwin_pending_rises", rises - r0, 1);

        // Load coinciding with the boundary
        step(5);
        do_load(16'h6666, 4'h0, 4'h0);
        wait_fd(cyc);
        push_frame(16'h6666, 4'h0, 4'h0);
        do_load(16'h5555, 4'h0, 4'h0);
        chk("boundary_load_pending", up, 1'b1);
        wait_fd(cyc);
        push_frame(16'h5555, 4'h0, 4'h0);
        step(1);
        chk("boundary_load_applied", up, 1'b0);

        // Blanking, dp, and reset during the digit-2 slot with a load pending
        step(3);
        do_load(16'hF0E7, 4'b0001, 4'b0100);
        wait_fd(cyc);
        push_frame(16'hF0E7, 4'b0001, 4'b1100);
        step(1);
        chk("blank_load_applied", up, 1'b0);
        step(10);
        do_load(16'h3333, 4'h0, 4'h0);
        chk("pending_before_reset", up, 1'b1);
        step(8);
        chk("blanked_digit2_an", an, 4'hF);
        #3 rst = 1'b1;
        #1;
        chk("midframe_reset_an", an, 4'hF);
        chk("midframe_reset_seg", seg, 7'h7F);
        chk("midframe_reset_pending", up, 1'b0);
        #2 rst = 1'b0;
        push_frame(16'h0000, 4'h0, 4'h0);
        wait_fd(cyc);
        chk("restart_frame_cycles", cyc, 31);
        chk("restart_no_pending", up, 1'b0);
        chk("expected_slots_left", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
